// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix in a final cycle.
module iter_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             sgn_q, sgn_d, div_q, div_d, done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_in_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign a_neg    = sgn_q & a_q[WIDTH-1];
  assign b_neg    = sgn_q & b_q[WIDTH-1];
  assign b_mag    = b_neg ? -b_q : b_q;
  // Signed ops are the even codes; magnitude of the most-negative value is its own pattern.
  assign a_in_mag = (~op[0] & a[WIDTH-1]) ? -a : a;

  // rem_q/quo_q act as {upper, lower} of the product or {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
  assign div_sh   = {rem_q, quo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_mag};
  assign prod     = {rem_q, quo_q};
  assign prod_neg = -prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    div_d   = div_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op)
            3'b100: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            3'b101: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            3'b000, 3'b001, 3'b010, 3'b011: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = ~op[0];
              div_d   = op[1];
              rem_d   = '0;
              quo_d   = a_in_mag;
              cnt_d   = '0;
              state_d = op[1] ? StDiv : StMul;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        rem_d = mul_sum[WIDTH:1];
        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) state_d = StFix;
      end
      StDiv: begin
        if (!div_diff[WIDTH]) begin
          rem_d = div_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) state_d = StFix;
      end
      StFix: begin
        if (!div_q) begin
          {hi_d, lo_d} = (a_neg ^ b_neg) ? prod_neg : prod;
        end else if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          lo_d = (a_neg ^ b_neg) ? -quo_q : quo_q;
          hi_d = a_neg ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_iter_mdu.sv
// Directed and randomized bench for iter_mdu (WIDTH=32) against an arithmetic HI/LO model.
module tb_iter_mdu;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] mhi, mlo;

  iter_mdu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // HI/LO semantics straight from the arithmetic definitions.
  function automatic void mdu_ref(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  inout logic [W-1:0] h, inout logic [W-1:0] l);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      3'd0: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'b0, av} * {32'b0, bv}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (bv == 0) begin l = '1; h = av; end
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin l = av; h = '0; end
        else begin l = 32'(sa / sb); h = 32'(sa % sb); end
      end
      3'd3: begin
        if (bv == 0) begin l = '1; h = av; end
        else begin l = av / bv; h = av % bv; end
      end
      3'd4: h = av;
      3'd5: l = av;
      default: ;
    endcase
  endfunction

  // Issue at the upcoming edge, follow to done, check timing and HI/LO.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int glitch_at);
    int k;
    int exp_lat;
    logic busy_ok;
    logic md;
    md      = (o < 3'd4);
    exp_lat = md ? W + 1 : 0;
    mdu_ref(o, av, bv, mhi, mlo);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_e0"}, 64'(busy), 64'(md));
    k = 0;
    busy_ok = 1'b1;
    while (!done && k < 40) begin
      @(negedge clk);
      start = (k + 1 == glitch_at);
      op = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 64'(k), 64'(exp_lat));
    check({tag, "_busy_held"}, 64'(busy_ok), 64'(1'b1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(1'b0));
    check({tag, "_hi"}, 64'(hi), 64'(mhi));
    check({tag, "_lo"}, 64'(lo), 64'(mlo));
  endtask

  initial begin
    int seen;
    logic [2:0] o;
    logic [W-1:0] av, bv;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    mhi = '0; mlo = '0;
    #22;
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_done", 64'(done), 64'(1'b0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 0);
    check("mult_neg1x2_const_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    check("mult_neg1x2_const_lo", 64'(lo), 64'(32'hFFFF_FFFE));
    run_op("multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    check("multu_const_hi", 64'(hi), 64'(32'h1));
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_m7_2_const_lo", 64'(lo), 64'(32'hFFFF_FFFD));
    check("div_m7_2_const_hi", 64'(hi), 64'(32'hFFFF_FFFF));
    run_op("divu_by0", 3'd3, 32'd7, 32'd0, 0);
    run_op("div_by0_neg", 3'd2, 32'hFFFF_FF00, 32'd0, 0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_const_lo", 64'(lo), 64'(32'h8000_0000));

    // Start during busy must be ignored; then back-to-back issue on the edge after done.
    run_op("multu_glitch", 3'd1, 32'd3, 32'd5, 5);
    check("multu_glitch_lo", 64'(lo), 64'(15));
    run_op("divu_b2b", 3'd3, 32'd9, 32'd2, 0);
    check("divu_b2b_lo", 64'(lo), 64'(4));
    check("divu_b2b_hi", 64'(hi), 64'(1));

    // Reserved op right after done: pulse must already be gone and nothing may change.
    start = 1'b1; op = 3'd6; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", 64'(done), 64'(1'b0));
    check("rsvd_busy", 64'(busy), 64'(1'b0));
    start = 1'b1; op = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rsvd_done", 64'(done), 64'(1'b0));
    check("rsvd_hi", 64'(hi), 64'(mhi));
    check("rsvd_lo", 64'(lo), 64'(mlo));

    // Abort a divide with reset mid-flight.
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mhi = '0; mlo = '0;
    check("abort_busy", 64'(busy), 64'(1'b0));
    check("abort_done", 64'(done), 64'(1'b0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'(0));
    run_op("mthi_after_abort", 3'd4, 32'h1234, 32'd0, 0);
    check("mthi_const_hi", 64'(hi), 64'(32'h1234));
    run_op("mtlo", 3'd5, 32'hDEAD_BEEF, 32'd0, 0);

    for (int i = 0; i < 30; i++) begin
      o  = 3'($urandom_range(0, 5));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 7))
        0: bv = '0;
        1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
        2: bv = 32'($urandom_range(1, 15));
        3: bv = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, o), o, av, bv, (i % 3 == 0) ? 7 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
